tl_sram_responder: RTL and testbench

TileLink-UH responder (slave) serving the data cache's uncached master port from an on-chip single-port SRAM. Accepts Get/PutFullData/PutPartialData on channel A, returns AccessAckData/AccessAck on channel D, including multi-beat line bursts. Sits on the far side of the memorySystem dcache A/D link, standing in for main memory in the SoC and in cache refill benches.

---
 rtl/tl_sram_responder.sv | 209 ++++++++++++++++++++
 tb/tb_tl_sram_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_sram_responder.sv
// tl_sram_responder: TileLink-UH responder serving Get / PutFullData /
// PutPartialData from an on-chip single-port SRAM (window base 0).
//
// Ports
//   cpu_clk_i, rst_i            clock, synchronous active-high reset
//   a_*  (in), a_ready (out)    channel A request beats
//   d_*  (out), d_ready (in)    channel D AccessAck / AccessAckData beats
//
// Build option
//   TL_SRAM_RESP_BURST_EN  when defined, sizes 3..5 are served as multi-beat
//                          bursts (2/4/8 beats). When undefined, any size > 2
//                          is denied and every transfer is a single beat.
//
// Unsupported opcodes get one denied AccessAckData beat (d_corrupt=1, data 0).
// Exactly one request is outstanding; a_ready is low while responding.
module tl_sram_responder #(
  parameter int ACP_RS      = 1,
  parameter int DEPTH_WORDS = 4096
) (
  input  logic              cpu_clk_i,
  input  logic              rst_i,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_param,
  input  logic [3:0]        a_size,
  input  logic [ACP_RS-1:0] a_source,
  input  logic [31:0]       a_address,
  input  logic [3:0]        a_mask,
  input  logic [31:0]       a_data,
  input  logic              a_corrupt,
  input  logic              a_valid,
  output logic              a_ready,
  output logic [2:0]        d_opcode,
  output logic [1:0]        d_param,
  output logic [3:0]        d_size,
  output logic [ACP_RS-1:0] d_source,
  output logic              d_denied,
  output logic [31:0]       d_data,
  output logic              d_corrupt,
  output logic              d_valid,
  input  logic              d_ready
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} state_e;
  state_e state, state_nxt;

  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0] addr_q;    // next word to read / write
  logic        deny_q;    // request-level deny latched at accept
  logic        cor_q;     // any Put beat so far was poisoned

  logic a_fire;
  assign a_fire  = a_valid & a_ready;
  assign a_ready = !rst_i && (state == IDLE || state == WRITE);
  assign d_param = 2'd0;

  logic unused_param;
  assign unused_param = ^a_param;

  // ---------------------------------------------------------------- decode
  logic       op_get, op_put, size_ok, misalign, oob, deny_req, put_single;
  logic [5:0] low_mask;
`ifdef TL_SRAM_RESP_BURST_EN
  logic [2:0] cnt, last_q, last_req;
  logic       beat_last;
  assign beat_last = (cnt == last_q);
`else
  logic       beat_last;
  assign beat_last = 1'b1;
`endif

  always_comb begin
    op_get   = (a_opcode == 3'd4);
    op_put   = (a_opcode == 3'd0) || (a_opcode == 3'd1);
`ifdef TL_SRAM_RESP_BURST_EN
    size_ok  = (a_size <= 4'd5);
`else
    size_ok  = (a_size <= 4'd2);
`endif
    low_mask = (6'd1 << a_size[2:0]) - 6'd1;
    misalign = |(a_address[5:0] & low_mask);
    // Aligned requests never straddle the top since the window is a
    // multiple of the largest transfer; checking the first word suffices.
    oob      = {2'b00, a_address[31:2]} >= 32'(DEPTH_WORDS);
    deny_req = !(op_get || op_put) || !size_ok || misalign || oob;
`ifdef TL_SRAM_RESP_BURST_EN
    last_req = 3'd0;
    if ((op_get || op_put) && size_ok && a_size > 4'd2)
      last_req = 3'((4'd1 << (a_size - 4'd2)) - 4'd1);
    put_single = (last_req == 3'd0);
`else
    put_single = 1'b1;
`endif
  end

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge cpu_clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (a_fire) state_nxt = !op_put ? READ : (put_single ? ACK : WRITE);
      READ:    if (d_valid && d_ready && beat_last) state_nxt = IDLE;
      WRITE:   if (a_fire && beat_last) state_nxt = ACK;
      ACK:     if (d_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------ SRAM write
  logic          wr_en;
  logic [AW-1:0] wr_idx;

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = a_address[AW+1:2];
    if (state == IDLE && a_fire && op_put && !deny_req && !a_corrupt)
      wr_en = 1'b1;
    if (state == WRITE && a_fire && !deny_q && !a_corrupt) begin
      wr_en  = 1'b1;
      wr_idx = addr_q[AW-1:0];
    end
  end

  always_ff @(posedge cpu_clk_i) begin
    if (wr_en)
      for (int i = 0; i < 4; i++)
        if (a_mask[i]) mem[wr_idx][8*i +: 8] <= a_data[8*i +: 8];
  end

  // ------------------------------------------------- request / D datapath
  always_ff @(posedge cpu_clk_i) begin
    if (rst_i) begin
      d_valid   <= 1'b0;
      d_opcode  <= 3'd0;
      d_size    <= 4'd0;
      d_source  <= '0;
      d_denied  <= 1'b0;
      d_data    <= 32'd0;
      d_corrupt <= 1'b0;
      addr_q    <= 30'd0;
      deny_q    <= 1'b0;
      cor_q     <= 1'b0;
`ifdef TL_SRAM_RESP_BURST_EN
      cnt       <= 3'd0;
      last_q    <= 3'd0;
`endif
    end else begin
      case (state)
        IDLE: if (a_fire) begin
          d_size   <= a_size;
          d_source <= a_source;
          d_data   <= 32'd0;
          deny_q   <= deny_req;
          cor_q    <= a_corrupt;
          // Put beat 0 is written now, so the WRITE pointer starts one ahead.
          addr_q   <= a_address[31:2] + {29'd0, op_put};
`ifdef TL_SRAM_RESP_BURST_EN
          last_q   <= last_req;
          cnt      <= op_put ? 3'd1 : 3'd0;
`endif
          if (op_put) begin
            d_opcode  <= ACCESS_ACK;
            d_corrupt <= 1'b0;
            d_denied  <= deny_req | a_corrupt;
            d_valid   <= put_single;
          end else begin
            d_opcode  <= ACCESS_ACK_DATA;
            d_denied  <= deny_req;
            d_corrupt <= deny_req;
          end
        end
        // d_data is the SRAM output register: it loads only when empty or
        // being consumed, so a stall freezes data, pointer and counter.
        READ: if (!d_valid || d_ready) begin
          if (d_valid && beat_last) begin
            d_valid <= 1'b0;
          end else begin
            d_valid <= 1'b1;
            d_data  <= deny_q ? 32'd0 : mem[addr_q[AW-1:0]];
            addr_q  <= addr_q + 30'd1;
`ifdef TL_SRAM_RESP_BURST_EN
            if (d_valid) cnt <= cnt + 3'd1;
`endif
          end
        end
        WRITE: if (a_fire) begin
          addr_q <= addr_q + 30'd1;
          cor_q  <= cor_q | a_corrupt;
          if (beat_last) begin
            d_valid  <= 1'b1;
            d_denied <= deny_q | cor_q | a_corrupt;
          end
`ifdef TL_SRAM_RESP_BURST_EN
          if (!beat_last) cnt <= cnt + 3'd1;
`endif
        end
        ACK: if (d_ready) d_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tl_sram_responder.sv
// Scoreboard bench for tl_sram_responder: issued requests push expected D
// beats computed from a word-array memory model; a negedge monitor pops and
// compares every D fire and checks D stability across stalls.
module tb_tl_sram_responder;
  localparam int DEPTH = 4096;
`ifdef TL_SRAM_RESP_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [2:0]  a_opcode = 3'd0, a_param = 3'd0;
  logic [3:0]  a_size = 4'd0, a_mask = 4'd0;
  logic [0:0]  a_source = 1'b0;
  logic [31:0] a_address = 32'd0, a_data = 32'd0;
  logic        a_corrupt = 1'b0, a_valid = 1'b0, a_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [0:0]  d_source;
  logic        d_denied, d_corrupt, d_valid;
  logic [31:0] d_data;
  logic        d_ready = 1'b0;

  always #5 clk = ~clk;

  tl_sram_responder #(.ACP_RS(1), .DEPTH_WORDS(DEPTH)) dut (
    .cpu_clk_i(clk), .rst_i(rst_i),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
    .a_valid(a_valid), .a_ready(a_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
    .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt),
    .d_valid(d_valid), .d_ready(d_ready)
  );

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  sz;
    logic        src;
    logic        den;
    logic        cor;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [DEPTH];
  int          checks = 0, errors = 0, pops = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // d_ready pattern, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       d_ready = 1'b1;
      1:       d_ready = ~d_ready;
      default: d_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: compare each D fire against the scoreboard head
  logic        held = 1'b0;
  logic [41:0] prev = '0;
  always @(negedge clk) begin
    if (rst_i) begin
      held = 1'b0;
    end else if (d_valid) begin
      if (held)
        chk("d_stable", {d_opcode, d_size, d_source, d_denied, d_corrupt, d_data}, prev);
      if (d_ready) begin
        chk("beat_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("d_opcode",  d_opcode,  e.op);
          chk("d_size",    d_size,    e.sz);
          chk("d_source",  d_source,  e.src);
          chk("d_denied",  d_denied,  e.den);
          chk("d_corrupt", d_corrupt, e.cor);
          chk("d_param",   d_param,   0);
          if (e.op == 3'd1) chk("d_data", d_data, e.data);
        end
        pops++;
      end
      held = !d_ready;
      prev = {d_opcode, d_size, d_source, d_denied, d_corrupt, d_data};
    end else begin
      held = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the beat fires.
  task automatic send_beat(input logic [2:0] op, input logic [3:0] sz, input logic src,
                           input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] data, input logic cor);
    int t = 0;
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
    a_address = addr; a_mask = mask; a_data = data; a_corrupt = cor;
    a_param = 3'($urandom_range(0, 7));
    while (!a_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!a_ready) begin
      chk("a_ready_timeout", 0, 1);
      a_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      a_valid = 1'b0;
    end
  endtask

  // Reference model: derive response beats from the request rules, update
  // the model memory, then drive the A beats.
  task automatic issue(input logic [2:0] op, input logic [3:0] sz, input logic src,
                       input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] data0, input bit incr, input int cor_beat);
    bit   is_get, is_put, size_ok, aligned, oob, deny, anycor;
    int   n, w;
    exp_t e;
    logic [31:0] d;
    is_get  = (op == 3'd4);
    is_put  = (op == 3'd0) || (op == 3'd1);
    size_ok = sz <= (BURST ? 4'd5 : 4'd2);
    aligned = size_ok && ((addr % (32'd1 << sz)) == 0);
    oob     = (addr >> 2) >= 32'(DEPTH);
    deny    = !(is_get || is_put) || !size_ok || !aligned || oob;
    n       = ((is_get || is_put) && size_ok && sz > 4'd2) ? (1 << (sz - 2)) : 1;
    w       = int'(addr >> 2);
    anycor  = (cor_beat >= 0) && (cor_beat < n);
    e.sz = sz; e.src = src;
    if (!is_put) begin
      for (int k = 0; k < n; k++) begin
        e.op = 3'd1; e.den = deny; e.cor = deny;
        e.data = deny ? 32'd0 : mem_m[w + k];
        exp_q.push_back(e);
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        d = incr ? data0 + 32'(k) : data0;
        if (!deny && k != cor_beat)
          for (int b = 0; b < 4; b++)
            if (mask[b]) mem_m[w + k][8*b +: 8] = d[8*b +: 8];
      end
      e.op = 3'd0; e.den = deny || anycor; e.cor = 1'b0; e.data = 32'd0;
      exp_q.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      d = incr ? data0 + 32'(k) : data0;
      send_beat(op, sz, src, addr, mask, d, (k == cor_beat));
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int p0, t;
    logic [2:0]  op;
    logic [3:0]  sz;
    logic [31:0] addr;
    int          r, cb;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ready",   a_ready,   0);
    chk("rst_d_valid",   d_valid,   0);
    chk("rst_d_opcode",  d_opcode,  0);
    chk("rst_d_param",   d_param,   0);
    chk("rst_d_size",    d_size,    0);
    chk("rst_d_source",  d_source,  0);
    chk("rst_d_denied",  d_denied,  0);
    chk("rst_d_data",    d_data,    0);
    chk("rst_d_corrupt", d_corrupt, 0);
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk("a_ready_after_reset", a_ready, 1);

    // prefill the test region so every read has defined contents
    for (int i = 0; i < 256; i++)
      issue(3'd0, 4'd2, 1'b0, 32'(i * 4), 4'hF, $urandom, 1'b0, -1);
    wait_drain();

    // full word put then get, with latency checks
    issue(3'd0, 4'd2, 1'b0, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0, -1);
    chk("put_ack_c1", d_valid, 1);
    chk("put_ack_opcode", d_opcode, 0);
    issue(3'd4, 4'd2, 1'b0, 32'h100, 4'hF, 32'd0, 1'b0, -1);
    chk("get_c1_idle", d_valid, 0);
    @(posedge clk); #1;
    chk("get_c2_valid", d_valid, 1);
    chk("get_c2_data", d_data, 32'hDEADBEEF);
    wait_drain();

    // partial put merges into existing word
    issue(3'd1, 4'd2, 1'b0, 32'h100, 4'h3, 32'h00001234, 1'b0, -1);
    issue(3'd4, 4'd2, 1'b0, 32'h100, 4'hF, 32'd0, 1'b0, -1);
    @(posedge clk); #1;
    chk("partial_data", d_data, 32'hDEAD1234);
    wait_drain();

    // line put then line get with d_ready toggling
    issue(3'd0, 4'd5, 1'b0, 32'h200, 4'hF, 32'd0, 1'b1, -1);
    wait_drain();
    rdy_mode = 1;
    issue(3'd4, 4'd5, 1'b0, 32'h200, 4'hF, 32'd0, 1'b0, -1);
    wait_drain();
    rdy_mode = 0;

    // denied requests: misaligned, out of window, denied put leaves memory alone
    issue(3'd4, 4'd2, 1'b0, 32'h102, 4'hF, 32'd0, 1'b0, -1);
    issue(3'd4, 4'd2, 1'b0, 32'(DEPTH * 4), 4'hF, 32'd0, 1'b0, -1);
    issue(3'd0, 4'd2, 1'b0, 32'h102, 4'hF, 32'hFFFFFFFF, 1'b0, -1);
    issue(3'd0, 4'd2, 1'b0, 32'h104, 4'hF, 32'h5555AAAA, 1'b0, 0);
    issue(3'd4, 4'd3, 1'b0, 32'h100, 4'hF, 32'd0, 1'b0, -1);
    // unsupported opcode, then a normal request
    issue(3'd2, 4'd2, 1'b1, 32'h100, 4'hF, 32'd0, 1'b0, -1);
    issue(3'd4, 4'd2, 1'b1, 32'h108, 4'hF, 32'd0, 1'b0, -1);
    wait_drain();

    // reset in the middle of a line read
    p0 = pops;
    issue(3'd4, 4'd5, 1'b0, 32'h200, 4'hF, 32'd0, 1'b0, -1);
    t = 0;
    while (pops < p0 + (BURST ? 3 : 0) && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("reset_reached_beat", 64'(pops >= p0 + (BURST ? 3 : 0)), 1);
    rst_i = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk("midrst_d_valid", d_valid, 0);
    chk("midrst_a_ready", a_ready, 0);
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk("postrst_a_ready", a_ready, 1);
    issue(3'd4, 4'd5, 1'b0, 32'h200, 4'hF, 32'd0, 1'b0, -1);
    wait_drain();

    // randomized traffic
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (r < 8)       op = 3'd4;
      else if (r < 13) op = 3'd0;
      else if (r < 18) op = 3'd1;
      else begin
        r = $urandom_range(0, 4);
        op = (r == 0) ? 3'd2 : (r == 1) ? 3'd3 : 3'(r + 3);
      end
      sz = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      r = $urandom_range(0, 19);
      if (r == 0)      addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 63) << 5);
      else if (r == 1) addr = 32'($urandom_range(0, 1023));
      else             addr = 32'($urandom_range(0, 1023)) & ~((32'd1 << sz[2:0]) - 32'd1);
      cb = (op <= 3'd1 && $urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
      issue(op, sz, 1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)),
            $urandom, 1'($urandom_range(0, 1)), cb);
    end
    wait_drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
